// File: rtl/lsf_rbin_stream_gen.sv
// lsf_rbin_stream_gen: computes r = x*cos + y*sin per hit, quantises it to a 7-bit bin and streams it to the histogram with event framing
module lsf_rbin_stream_gen #(
   parameter int COORD_W  = 12,
   parameter int COEF_W   = 10,
   parameter int R_SHIFT  = 2,
   parameter int R_OFFSET = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               event_start,
   input  logic [COEF_W-1:0]  cos_coef,
   input  logic [COEF_W-1:0]  sin_coef,
   input  logic [COORD_W-1:0] hit_x,
   input  logic [COORD_W-1:0] hit_y,
   input  logic               hit_valid,
   input  logic               hit_last,
   output logic               hit_ready,
   output logic [7:0]         r_bin_V_TDATA,
   output logic               r_bin_V_TVALID,
   input  logic               r_bin_V_TREADY,
   output logic               reset_V,
   output logic               enable_V,
   output logic               event_done
);
   localparam int COEF_FRAC = 9;
   localparam int PW = COORD_W + COEF_W;
   localparam int SH = COEF_FRAC + R_SHIFT;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t                    r_state;
   logic signed [COEF_W-1:0]  r_cos, r_sin;
   logic                      r_reset_v, r_enable, r_done;
   logic                      r_s1_v, r_s2_v, r_tvalid;
   logic signed [PW-1:0]      r_px, r_py;
   logic [7:0]                r_s2_data, r_tdata;
   logic                      w_stall, w_accept, w_empty, w_oor;
   logic signed [PW+1:0]      w_sum, w_r;
   logic [7:0]                w_bin;

   assign w_stall   = r_tvalid && !r_bin_V_TREADY;
   assign hit_ready = (r_state == S_STREAM) && !w_stall;
   assign w_accept  = hit_valid && hit_ready;
   assign w_empty   = !r_s1_v && !r_s2_v && !r_tvalid;

   // Sum is two bits wider than a product so shift and offset never truncate
   assign w_sum = $signed({{2{r_px[PW-1]}}, r_px}) + $signed({{2{r_py[PW-1]}}, r_py});
   assign w_r   = (w_sum >>> SH) + $signed((PW+2)'(R_OFFSET));
   assign w_oor = |w_r[PW+1:7];
   assign w_bin = w_oor ? 8'h80 : {1'b0, w_r[6:0]};

   assign r_bin_V_TDATA  = r_tdata;
   assign r_bin_V_TVALID = r_tvalid;
   assign reset_V        = r_reset_v;
   assign enable_V       = r_enable;
   assign event_done     = r_done;

   // Event framing FSM: latch coefficients, pulse histogram clear, stream, drain, signal done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cos     <= '0;
         r_sin     <= '0;
         r_reset_v <= 1'b0;
         r_enable  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (event_start) begin
               r_cos     <= $signed(cos_coef);
               r_sin     <= $signed(sin_coef);
               r_reset_v <= 1'b1;
               r_enable  <= 1'b1;
               r_state   <= S_CLEAR;
            end
            S_CLEAR: begin
               r_reset_v <= 1'b0;
               r_state   <= S_STREAM;
            end
            S_STREAM: if (w_accept && hit_last) r_state <= S_DRAIN;
            S_DRAIN: if (w_empty) begin
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Three-stage datapath (products, bin, AXI output) frozen as a whole while the output is stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_v    <= 1'b0;
         r_s2_v    <= 1'b0;
         r_tvalid  <= 1'b0;
         r_px      <= '0;
         r_py      <= '0;
         r_s2_data <= '0;
         r_tdata   <= '0;
      end else if (!w_stall) begin
         r_s1_v    <= w_accept;
         if (w_accept) begin
            r_px <= PW'($signed(hit_x)) * PW'(r_cos);
            r_py <= PW'($signed(hit_y)) * PW'(r_sin);
         end
         r_s2_v    <= r_s1_v;
         r_s2_data <= w_bin;
         r_tvalid  <= r_s2_v;
         r_tdata   <= r_s2_data;
      end
   end
endmodule

// File: tb/tb_lsf_rbin_stream_gen.sv
// tb_lsf_rbin_stream_gen: directed checks of binning, latency, framing, backpressure, async reset and coefficient latching
module tb_lsf_rbin_stream_gen;
   logic        clk = 1'b0, rst = 1'b1, event_start = 1'b0;
   logic [9:0]  cos_coef = '0, sin_coef = '0;
   logic [11:0] hit_x = '0, hit_y = '0;
   logic        hit_valid = 1'b0, hit_last = 1'b0, hit_ready;
   logic [7:0]  tdata;
   logic        tvalid, tready = 1'b1;
   logic        reset_v, enable_v, event_done;

   int          n_vec = 0, n_err = 0;
   logic [7:0]  cap [0:63];
   int          ncap = 0, ndone = 0, nrst = 0, nstab = 0, nstab_bad = 0;
   logic        held = 1'b0;
   logic [7:0]  held_d = '0;

   always #5 clk = ~clk;

   lsf_rbin_stream_gen dut (
      .clk(clk), .rst(rst), .event_start(event_start),
      .cos_coef(cos_coef), .sin_coef(sin_coef),
      .hit_x(hit_x), .hit_y(hit_y), .hit_valid(hit_valid), .hit_last(hit_last),
      .hit_ready(hit_ready),
      .r_bin_V_TDATA(tdata), .r_bin_V_TVALID(tvalid), .r_bin_V_TREADY(tready),
      .reset_V(reset_v), .enable_V(enable_v), .event_done(event_done)
   );

   // Mid-cycle monitor: captures handshaken beats, counts pulses, checks held data stays put
   always @(negedge clk) begin
      if (held) begin
         nstab <= nstab + 1;
         if (!(tvalid === 1'b1 && tdata === held_d)) nstab_bad <= nstab_bad + 1;
      end
      held   <= tvalid && !tready;
      held_d <= tdata;
      if (tvalid && tready && ncap < 64) begin
         cap[ncap] <= tdata;
         ncap      <= ncap + 1;
      end
      if (event_done) ndone <= ndone + 1;
      if (reset_v) nrst <= nrst + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_ev(input logic [9:0] c, input logic [9:0] s);
      cos_coef    = c;
      sin_coef    = s;
      event_start = 1'b1;
      tick();
      event_start = 1'b0;
   endtask

   task automatic send(input logic [11:0] x, input logic [11:0] y, input logic last);
      logic ok;
      ok        = 1'b0;
      hit_x     = x;
      hit_y     = y;
      hit_last  = last;
      hit_valid = 1'b1;
      for (int b = 0; b < 50 && !ok; b++) begin
         #1;
         ok = hit_ready;
         tick();
      end
      chk("send_accept", {31'b0, ok}, 32'd1);
      hit_valid = 1'b0;
      hit_last  = 1'b0;
   endtask

   task automatic wait_done();
      for (int b = 0; b < 60 && !event_done; b++) tick();
      chk("done_seen", {31'b0, event_done}, 32'd1);
      tick();
   endtask

   initial begin
      int         b, d0, r0, s0, k;
      logic       acc;
      logic [7:0] pat;
      pat = 8'h69;
      // reset state, with a hit offered during reset
      hit_valid = 1'b1;
      hit_x     = 12'd200;
      tick();
      tick();
      chk("rst_tvalid", {31'b0, tvalid}, 32'd0);
      chk("rst_tdata", {24'b0, tdata}, 32'd0);
      chk("rst_reset_v", {31'b0, reset_v}, 32'd0);
      chk("rst_enable", {31'b0, enable_v}, 32'd0);
      chk("rst_done", {31'b0, event_done}, 32'd0);
      chk("rst_ready", {31'b0, hit_ready}, 32'd0);
      rst = 1'b0;
      // hits without event_start are never accepted
      tick();
      tick();
      tick();
      chk("idle_ready", {31'b0, hit_ready}, 32'd0);
      tick();
      chk("idle_tvalid", {31'b0, tvalid}, 32'd0);
      hit_valid = 1'b0;
      // nominal event: latency and bins for x=200 and x=-200
      start_ev(10'd256, 10'd0);
      chk("a_clear_reset_v", {31'b0, reset_v}, 32'd1);
      chk("a_clear_ready", {31'b0, hit_ready}, 32'd0);
      chk("a_clear_enable", {31'b0, enable_v}, 32'd1);
      tick();
      chk("a_stream_reset_v", {31'b0, reset_v}, 32'd0);
      chk("a_stream_ready", {31'b0, hit_ready}, 32'd1);
      hit_valid = 1'b1;
      hit_x     = 12'd200;
      hit_y     = 12'd0;
      tick();
      hit_x     = -12'd200;
      hit_last  = 1'b1;
      tick();
      hit_valid = 1'b0;
      hit_last  = 1'b0;
      chk("a_lat_n1", {31'b0, tvalid}, 32'd0);
      tick();
      chk("a_lat_n2_valid", {31'b0, tvalid}, 32'd1);
      chk("a_bin_pos", {24'b0, tdata}, 32'h59);
      tick();
      chk("a_bin_neg_valid", {31'b0, tvalid}, 32'd1);
      chk("a_bin_neg", {24'b0, tdata}, 32'h27);
      tick();
      chk("a_drained", {31'b0, tvalid}, 32'd0);
      chk("a_done_early", {31'b0, event_done}, 32'd0);
      tick();
      chk("a_done", {31'b0, event_done}, 32'd1);
      tick();
      chk("a_done_pulse", {31'b0, event_done}, 32'd0);
      chk("a_idle_ready", {31'b0, hit_ready}, 32'd0);
      chk("a_enable_hold", {31'b0, enable_v}, 32'd1);
      // out-of-range flags on both sides plus an in-range bin
      b = ncap;
      start_ev(10'd511, 10'd511);
      tick();
      send(12'd2047, 12'd2047, 1'b0);
      send(-12'd2048, 12'd0, 1'b0);
      send(12'd0, 12'd0, 1'b1);
      wait_done();
      chk("b_count", ncap - b, 32'd3);
      chk("b_over", {24'b0, cap[b]}, 32'h80);
      chk("b_under", {24'b0, cap[b+1]}, 32'h80);
      chk("b_zero", {24'b0, cap[b+2]}, 32'h40);
      // framing: 5 hits, stray event_start and coefficient change mid-event
      b  = ncap;
      d0 = ndone;
      r0 = nrst;
      start_ev(10'd256, 10'd0);
      chk("c_clear_reset_v", {31'b0, reset_v}, 32'd1);
      chk("c_clear_ready", {31'b0, hit_ready}, 32'd0);
      tick();
      chk("c_stream_ready", {31'b0, hit_ready}, 32'd1);
      send(12'd0, 12'd0, 1'b0);
      send(12'd40, 12'd0, 1'b0);
      cos_coef    = 10'd128;
      event_start = 1'b1;
      send(12'd80, 12'd0, 1'b0);
      event_start = 1'b0;
      send(-12'd40, 12'd0, 1'b0);
      send(12'd200, 12'd0, 1'b1);
      wait_done();
      tick();
      tick();
      chk("c_count", ncap - b, 32'd5);
      chk("c_beat0", {24'b0, cap[b]}, 32'h40);
      chk("c_beat1", {24'b0, cap[b+1]}, 32'h45);
      chk("c_beat2", {24'b0, cap[b+2]}, 32'h4A);
      chk("c_beat3", {24'b0, cap[b+3]}, 32'h3B);
      chk("c_beat4", {24'b0, cap[b+4]}, 32'h59);
      chk("c_done_once", ndone - d0, 32'd1);
      chk("c_reset_once", nrst - r0, 32'd1);
      // next event picks up the new coefficient
      b = ncap;
      start_ev(10'd128, 10'd0);
      tick();
      send(12'd200, 12'd0, 1'b1);
      wait_done();
      chk("l_count", ncap - b, 32'd1);
      chk("l_bin", {24'b0, cap[b]}, 32'h4C);
      // backpressure with TREADY pattern 1,0,0,1,0,1,1,0
      b  = ncap;
      s0 = nstab;
      d0 = ndone;
      k  = 0;
      start_ev(10'd256, 10'd0);
      tick();
      for (int c = 0; c < 80; c++) begin
         tready = pat[c % 8];
         if (k < 8) begin
            hit_valid = 1'b1;
            hit_x     = 12'(8 * k);
            hit_y     = 12'd0;
            hit_last  = (k == 7);
         end else begin
            hit_valid = 1'b0;
            hit_last  = 1'b0;
         end
         #1;
         acc = hit_valid && hit_ready;
         tick();
         if (acc) k++;
      end
      tready    = 1'b1;
      hit_valid = 1'b0;
      hit_last  = 1'b0;
      tick();
      tick();
      chk("d_accepted", k, 32'd8);
      chk("d_count", ncap - b, 32'd8);
      for (int i = 0; i < 8; i++) chk("d_beat", {24'b0, cap[b+i]}, 32'h40 + i);
      chk("d_stalled", {31'b0, nstab > s0}, 32'd1);
      chk("d_stable", nstab_bad, 32'd0);
      chk("d_done_once", ndone - d0, 32'd1);
      // async reset with beats in flight, then a clean event
      start_ev(10'd256, 10'd0);
      tick();
      send(12'd200, 12'd0, 1'b0);
      send(12'd200, 12'd0, 1'b0);
      send(12'd200, 12'd0, 1'b0);
      chk("e_inflight", {31'b0, tvalid}, 32'd1);
      b = ncap;
      #2;
      rst = 1'b1;
      #1;
      chk("e_tvalid", {31'b0, tvalid}, 32'd0);
      chk("e_enable", {31'b0, enable_v}, 32'd0);
      chk("e_ready", {31'b0, hit_ready}, 32'd0);
      chk("e_done", {31'b0, event_done}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
      chk("e_no_beats", ncap - b, 32'd0);
      chk("e_idle_ready", {31'b0, hit_ready}, 32'd0);
      start_ev(10'd256, 10'd0);
      chk("e_clear_reset_v", {31'b0, reset_v}, 32'd1);
      tick();
      send(-12'd200, 12'd0, 1'b1);
      wait_done();
      chk("e_count", ncap - b, 32'd1);
      chk("e_bin", {24'b0, cap[b]}, 32'h27);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
